// File: rtl/rt_pkg.sv
// Shared definitions for the multi-player reaction timer.
// Contents: round state enum, LFSR seed/taps and step function, ms prescaler divisor.
package rt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_GO    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } rt_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting left; taps on bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned CLK_HZ_DEFAULT = 25_000_000;
    localparam int unsigned MS_DIV         = CLK_HZ_DEFAULT / 1000;

    // Cycles per ms tick for a given clock; never below one
    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return (clk_hz >= 1000) ? (clk_hz / 1000) : 1;
    endfunction

    // One LFSR step; a nonzero state never reaches all-zero
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rt_ms_tick.sv
// Millisecond prescaler: emits a one-cycle tick every DIV cycles.
// Ports: clk, rst (async, active-high), clr (sync restart of the period), tick (registered pulse).
module rt_ms_tick #(
    parameter int unsigned DIV = 25_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // After a clear the first tick appears DIV cycles later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction-time core: random arm delay, stimulus, per-player ms
// reaction times, false-start detection, first-responder and best-time record.
// Ports: clk, rst (async, active-high), start, btn[NUM_PLAYERS];
//        stim_led, busy, done (pulse), false_start, timed_out, time_ms (packed
//        per player), winner, winner_valid, best_ms. All outputs registered.
module reaction_timer_multi
    import rt_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned CLK_HZ       = 25_000_000,
    parameter int unsigned TIME_W       = 14,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_W       = 11,
    parameter int unsigned TIMEOUT_MS   = 9999,
    localparam int unsigned WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_PLAYERS-1:0]        btn,
    output logic                          stim_led,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PLAYERS-1:0]        false_start,
    output logic [NUM_PLAYERS-1:0]        timed_out,
    output logic [NUM_PLAYERS*TIME_W-1:0] time_ms,
    output logic [WIN_W-1:0]              winner,
    output logic                          winner_valid,
    output logic [TIME_W-1:0]             best_ms
);

    localparam int unsigned TICK_DIV = ms_div(CLK_HZ);
    localparam int unsigned DLY_W    = $clog2(MIN_DELAY_MS + (1 << RAND_W));
    localparam logic [TIME_W-1:0] T_MAX = TIME_W'(TIMEOUT_MS);

    rt_state_t              state, next_state;
    logic [15:0]            lfsr;
    logic [NUM_PLAYERS-1:0] btn_q, rise, pressed, new_press;
    logic                   tick, tick_clr, accept, all_pressed, time_up;
    logic [DLY_W-1:0]       delay;
    logic [TIME_W-1:0]      ms_cnt, win_time, best_cand;
    logic [WIN_W-1:0]       first_idx;

    rt_ms_tick #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Rising edges; a button held across GO entry has no edge until re-pressed
    assign rise        = btn & ~btn_q;
    assign new_press   = (state == ST_GO) ? (rise & ~pressed) : '0;
    assign all_pressed = &(pressed | new_press);
    assign time_up     = (ms_cnt == T_MAX);
    // If the first press lands in the exit cycle, its time is the live counter
    assign best_cand   = winner_valid ? win_time : ms_cnt;

    // Lowest-index new press wins a same-cycle tie
    always_comb begin
        first_idx = '0;
        for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
            if (new_press[i]) first_idx = WIN_W'(i);
        end
    end

    // Next-state and control strobes
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        tick_clr   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    next_state = ST_ARMED;
                    accept     = 1'b1;
                    tick_clr   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (|rise) begin
                    next_state = ST_FAULT;
                end else if (tick && (delay <= DLY_W'(1))) begin
                    next_state = ST_GO;
                    tick_clr   = 1'b1;
                end
            end
            ST_GO: begin
                if (all_pressed || time_up) next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            btn_q        <= '0;
            stim_led     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            false_start  <= '0;
            timed_out    <= '0;
            time_ms      <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            best_ms      <= '1;
            delay        <= '0;
            ms_cnt       <= '0;
            pressed      <= '0;
            win_time     <= '0;
        end else begin
            lfsr     <= lfsr_next(lfsr);
            btn_q    <= btn;
            stim_led <= (next_state == ST_GO);
            busy     <= (next_state == ST_ARMED) || (next_state == ST_GO);
            done     <= ((state == ST_ARMED) || (state == ST_GO)) &&
                        ((next_state == ST_DONE) || (next_state == ST_FAULT));

            if (accept) begin
                false_start  <= '0;
                timed_out    <= '0;
                time_ms      <= '0;
                winner       <= '0;
                winner_valid <= 1'b0;
                pressed      <= '0;
                delay        <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_W-1:0]);
            end

            case (state)
                ST_ARMED: begin
                    if (|rise) begin
                        false_start <= rise;
                    end else if (next_state == ST_GO) begin
                        ms_cnt  <= '0;
                        pressed <= '0;
                    end else if (tick) begin
                        delay <= delay - DLY_W'(1);
                    end
                end
                ST_GO: begin
                    if (tick && !time_up) ms_cnt <= ms_cnt + TIME_W'(1);
                    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                        if (new_press[i]) begin
                            time_ms[i*TIME_W +: TIME_W] <= ms_cnt;
                            pressed[i]                  <= 1'b1;
                        end else if ((next_state == ST_DONE) && !pressed[i]) begin
                            time_ms[i*TIME_W +: TIME_W] <= T_MAX;
                            timed_out[i]                <= 1'b1;
                        end
                    end
                    if (!winner_valid && (|new_press)) begin
                        winner       <= first_idx;
                        winner_valid <= 1'b1;
                        win_time     <= ms_cnt;
                    end
                    if ((next_state == ST_DONE) && (winner_valid || (|new_press)) &&
                        (best_cand < best_ms)) begin
                        best_ms <= best_cand;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Self-checking bench for reaction_timer_multi (4 cycles per ms, 2 players,
// 3..6 ms random arm delay, 20 ms timeout).
module tb_reaction_timer_multi;

    localparam int unsigned NP   = 2;
    localparam int unsigned TW   = 14;
    localparam int unsigned TO   = 20;
    localparam int unsigned MIND = 3;
    localparam int unsigned RW   = 2;
    localparam int unsigned DIV  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [NP-1:0]  btn;
    logic           stim_led, busy, done, winner_valid;
    logic [NP-1:0]  false_start, timed_out;
    logic [NP*TW-1:0] time_ms;
    logic [0:0]     winner;
    logic [TW-1:0]  best_ms;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int stim_cyc = 0;
    int m_best;
    logic [15:0] m_lfsr;

    reaction_timer_multi #(
        .NUM_PLAYERS (NP),
        .CLK_HZ      (DIV * 1000),
        .TIME_W      (TW),
        .MIN_DELAY_MS(MIND),
        .RAND_W      (RW),
        .TIMEOUT_MS  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .btn         (btn),
        .stim_led    (stim_led),
        .busy        (busy),
        .done        (done),
        .false_start (false_start),
        .timed_out   (timed_out),
        .time_ms     (time_ms),
        .winner      (winner),
        .winner_valid(winner_valid),
        .best_ms     (best_ms)
    );

    always #5 clk = ~clk;

    // Reference pseudo-random source: x^16+x^14+x^13+x^11+1 from seed ACE1
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Count done pulses and lit cycles, one sample per clock period
    always @(posedge clk) begin
        if (done)     done_cnt++;
        if (stim_led) stim_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int tm(input int i);
        logic [NP*TW-1:0] v;
        v = time_ms;
        return int'(v[i*TW +: TW]);
    endfunction

    // Issue a start at a negedge; returns the delay in ms the DUT should use
    task automatic start_round(output int d);
        d = int'(MIND) + int'(m_lfsr[RW-1:0]);
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("stim_after_start", 32'(stim_led), 32'd0);
        check("clear_fs", 32'(false_start), 32'd0);
        check("clear_to", 32'(timed_out), 32'd0);
        check("clear_wv", 32'(winner_valid), 32'd0);
        check("clear_time", time_ms, 32'd0);
    endtask

    // Count cycles from the start edge until the stimulus lights
    task automatic wait_go(input int d);
        int cyc;
        cyc = 0;
        while (!stim_led && cyc < 200) begin
            step();
            cyc++;
        end
        check("arm_len", 32'(cyc), 32'(4 * d + 1));
    endtask

    // Play out GO: offsets are clock edges after GO entry (0 = never presses).
    // A press sampled at edge offset o reads floor((o-2)/4) ms.
    task automatic play(input int o0, input int o1, input bit hold0, input int rel0, input int sgo);
        int o[2];
        int first, endo, wexp, dc0;
        int texp[2];
        logic [1:0] toexp;
        o[0] = o0;
        o[1] = o1;
        first = 0;
        for (int i = 0; i < 2; i++)
            if (o[i] != 0 && (first == 0 || o[i] < first)) first = o[i];
        wexp = (o0 != 0 && o0 == first) ? 0 : 1;
        endo = (o0 != 0 && o1 != 0) ? ((o0 > o1) ? o0 : o1) : int'(4 * TO + 2);
        toexp = '0;
        for (int i = 0; i < 2; i++) begin
            if (o[i] != 0) texp[i] = (o[i] - 2) / 4;
            else begin
                texp[i] = int'(TO);
                toexp[i] = 1'b1;
            end
        end
        dc0 = done_cnt;
        for (int off = 1; off <= endo; off++) begin
            btn[0] = (hold0 && off < rel0) || (o0 != 0 && off >= o0);
            btn[1] = (o1 != 0 && off >= o1);
            start  = (off == sgo);
            step();
            if (off == first) begin
                check("wv_after_first", 32'(winner_valid), 32'd1);
                check("winner_after_first", 32'(winner), 32'(wexp));
            end
            if (off == endo) begin
                check("done_at_end", 32'(done), 32'd1);
                check("busy_at_end", 32'(busy), 32'd0);
                check("stim_at_end", 32'(stim_led), 32'd0);
            end
        end
        start = 1'b0;
        btn = '0;
        repeat (3) step();
        if (first != 0 && texp[wexp] < m_best) m_best = texp[wexp];
        check("done_once", 32'(done_cnt - dc0), 32'd1);
        check("time0", 32'(tm(0)), 32'(texp[0]));
        check("time1", 32'(tm(1)), 32'(texp[1]));
        check("timed_out", 32'(timed_out), 32'(toexp));
        check("winner_valid", 32'(winner_valid), 32'(first != 0));
        check("winner", 32'(winner), (first != 0) ? 32'(wexp) : 32'd0);
        check("best_ms", 32'(best_ms), 32'(m_best));
        check("fs_clear_in_done", 32'(false_start), 32'd0);
    endtask

    function automatic int rand_off();
        if ($urandom_range(0, 3) == 0) return 0;
        return 4 * int'($urandom_range(1, 18)) + 2 + int'($urandom_range(0, 3));
    endfunction

    initial begin
        int d, dc0, sc0, w, r, o0, o1;
        rst = 1'b1;
        start = 1'b0;
        btn = '0;
        m_best = 16383;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_stim", 32'(stim_led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wv", 32'(winner_valid), 32'd0);
        check("rst_fs", 32'(false_start), 32'd0);
        check("rst_to", 32'(timed_out), 32'd0);
        check("rst_time", time_ms, 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_best", 32'(best_ms), 32'h3FFF);
        rst = 1'b0;
        repeat (2) step();

        // Reset in the middle of GO
        start_round(d);
        wait_go(d);
        repeat (5) step();
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        check("midgo_rst_stim", 32'(stim_led), 32'd0);
        check("midgo_rst_busy", 32'(busy), 32'd0);
        check("midgo_rst_best", 32'(best_ms), 32'h3FFF);
        @(negedge clk);
        step();
        check("midgo_rst_nodone", 32'(done_cnt - dc0), 32'd0);
        rst = 1'b0;
        m_best = 16383;
        repeat (2) step();
        check("idle_after_rst", 32'(busy), 32'd0);

        // Player 1 at 5 ms, player 0 at 8 ms
        start_round(d);
        wait_go(d);
        play(4 * 8 + 2 + int'($urandom_range(0, 3)), 4 * 5 + 2 + int'($urandom_range(0, 3)), 1'b0, 0, 0);

        // False start by player 0 while armed
        sc0 = stim_cyc;
        start_round(d);
        dc0 = done_cnt;
        w = int'($urandom_range(0, 8));
        repeat (w) step();
        btn[0] = 1'b1;
        step();
        check("fault_done", 32'(done), 32'd1);
        check("fault_fs", 32'(false_start), 32'd1);
        check("fault_busy", 32'(busy), 32'd0);
        check("fault_stim", 32'(stim_led), 32'd0);
        btn = '0;
        repeat (3) step();
        check("fault_done_once", 32'(done_cnt - dc0), 32'd1);
        check("fault_no_stim", 32'(stim_cyc - sc0), 32'd0);
        check("fault_fs_held", 32'(false_start), 32'd1);
        check("fault_best", 32'(best_ms), 32'(m_best));

        // No presses: timeout
        start_round(d);
        wait_go(d);
        play(0, 0, 1'b0, 0, 0);

        // Both players rise in the same cycle at 3 ms
        r = 4 * 3 + 2 + int'($urandom_range(0, 3));
        start_round(d);
        wait_go(d);
        play(r, r, 1'b0, 0, 0);

        // Player 0 held across GO entry, re-presses at 6 ms; start during GO ignored
        btn[0] = 1'b1;
        step();
        start_round(d);
        wait_go(d);
        play(4 * 6 + 2 + int'($urandom_range(0, 3)), 0, 1'b1,
             int'($urandom_range(2, 12)), int'($urandom_range(1, 20)));

        // Randomised rounds
        for (int k = 0; k < 5; k++) begin
            o0 = rand_off();
            o1 = rand_off();
            start_round(d);
            wait_go(d);
            play(o0, o1, 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
